// File: rtl/adjust_pulse_router.sv
// ============================================================================
// Module      : adjust_pulse_router
// Description : Steers the clear and increment front-panel buttons to one of
//               N_CH time/alarm channels as one-cycle one-hot pulses, with
//               button synchronisation, select latching, increment
//               auto-repeat and clear-priority lockout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adjust_pulse_router #(
    parameter int N_CH          = 4,
    parameter int SEL_W         = 2,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 25
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR_BTN,
    input  logic             INC_BTN,
    input  logic [SEL_W-1:0] SEL,
    output logic [N_CH-1:0]  CLR,
    output logic [N_CH-1:0]  INC,
    output logic [SEL_W-1:0] ACTIVE_SEL,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_WAIT = 2'd1,
        ST_REPEAT    = 2'd2,
        ST_LOCKOUT   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    // Bit 0 carries the clear button, bit 1 the increment button.
    logic [1:0]       r_sync1_q, r_sync2_q, r_sync3_q, r_edge_q, r_arm_q;
    logic [1:0]       w_sync1_d, w_sync2_d, w_sync3_d, w_edge_d, w_arm_d;
    logic             r_settled_q, w_settled_d;

    state_t           r_state_q, w_state_d;
    logic [CNT_W-1:0] r_timer_q, w_timer_d;
    logic [N_CH-1:0]  r_clr_q, w_clr_d;
    logic [N_CH-1:0]  r_inc_q, w_inc_d;
    logic [SEL_W-1:0] r_active_sel_q, w_active_sel_d;

    logic [N_CH-1:0]  w_sel_dec, w_act_dec;

    // One-hot channel decode; an out-of-range select decodes to all zeros.
    function automatic logic [N_CH-1:0] decode(input logic [SEL_W-1:0] s);
        logic [N_CH-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s == SEL_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Synchroniser chain, history flop and registered rising-edge detect.
    // A button is only armed once it has been seen released after reset, so a
    // button still held through reset cannot masquerade as a fresh press.
    always_comb begin
        w_sync1_d   = {INC_BTN, CLR_BTN};
        w_sync2_d   = r_sync1_q;
        w_sync3_d   = r_sync2_q;
        w_settled_d = 1'b1;
        w_arm_d     = r_arm_q | ({2{r_settled_q}} & ~r_sync1_q);
        w_edge_d    = r_sync2_q & ~r_sync3_q & r_arm_q;
    end

    // Front-end registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sync1_q   <= '0;
            r_sync2_q   <= '0;
            r_sync3_q   <= '0;
            r_edge_q    <= '0;
            r_arm_q     <= '0;
            r_settled_q <= 1'b0;
        end else begin
            r_sync1_q   <= w_sync1_d;
            r_sync2_q   <= w_sync2_d;
            r_sync3_q   <= w_sync3_d;
            r_edge_q    <= w_edge_d;
            r_arm_q     <= w_arm_d;
            r_settled_q <= w_settled_d;
        end
    end

    // Next-state, timer and pulse decisions; clear always beats increment.
    always_comb begin
        w_state_d      = r_state_q;
        w_timer_d      = r_timer_q;
        w_clr_d        = '0;
        w_inc_d        = '0;
        w_active_sel_d = r_active_sel_q;
        w_sel_dec      = decode(SEL);
        w_act_dec      = decode(r_active_sel_q);
        case (r_state_q)
            ST_IDLE: begin
                if (r_edge_q[0]) begin
                    w_clr_d        = w_sel_dec;
                    w_active_sel_d = SEL;
                    w_state_d      = ST_LOCKOUT;
                end else if (r_edge_q[1]) begin
                    w_inc_d        = w_sel_dec;
                    w_active_sel_d = SEL;
                    w_timer_d      = '0;
                    w_state_d      = ST_HOLD_WAIT;
                end
            end
            ST_HOLD_WAIT, ST_REPEAT: begin
                if (r_edge_q[0]) begin
                    w_clr_d   = w_act_dec;
                    w_timer_d = '0;
                    w_state_d = ST_LOCKOUT;
                end else if (!r_sync3_q[1]) begin
                    w_timer_d = '0;
                    w_state_d = ST_IDLE;
                end else if (r_timer_q == ((r_state_q == ST_HOLD_WAIT) ? C_HOLD_LAST
                                                                        : C_REPEAT_LAST)) begin
                    w_inc_d   = w_act_dec;
                    w_timer_d = '0;
                    w_state_d = ST_REPEAT;
                end else begin
                    w_timer_d = r_timer_q + 1'b1;
                end
            end
            ST_LOCKOUT: begin
                if (r_sync3_q == 2'b00) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // FSM state, timer and registered outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state_q      <= ST_IDLE;
            r_timer_q      <= '0;
            r_clr_q        <= '0;
            r_inc_q        <= '0;
            r_active_sel_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_timer_q      <= w_timer_d;
            r_clr_q        <= w_clr_d;
            r_inc_q        <= w_inc_d;
            r_active_sel_q <= w_active_sel_d;
        end
    end

    assign CLR        = r_clr_q;
    assign INC        = r_inc_q;
    assign ACTIVE_SEL = r_active_sel_q;
    assign BUSY       = (r_state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_adjust_pulse_router.sv
// ============================================================================
// Module      : tb_adjust_pulse_router
// Description : Scoreboard bench for adjust_pulse_router. Stimulus pushes the
//               expected pulses (cycle, CLR, INC) into a queue; a monitor pops
//               and compares whenever a pulse is presented.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adjust_pulse_router;

    localparam int C_N_CH   = 3;
    localparam int C_SEL_W  = 2;
    localparam int C_HOLD   = 8;
    localparam int C_REPEAT = 3;
    localparam int C_CNT_W  = 4;

    logic               clk;
    logic               rst;
    logic               clr_btn;
    logic               inc_btn;
    logic [C_SEL_W-1:0] sel;
    logic [C_N_CH-1:0]  clr;
    logic [C_N_CH-1:0]  inc;
    logic [C_SEL_W-1:0] active_sel;
    logic               busy;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int         t;
        logic [2:0] clr;
        logic [2:0] inc;
    } exp_t;

    exp_t exp_q[$];

    adjust_pulse_router #(
        .N_CH         (C_N_CH),
        .SEL_W        (C_SEL_W),
        .HOLD_CYCLES  (C_HOLD),
        .REPEAT_CYCLES(C_REPEAT),
        .CNT_W        (C_CNT_W)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .CLR_BTN   (clr_btn),
        .INC_BTN   (inc_btn),
        .SEL       (sel),
        .CLR       (clr),
        .INC       (inc),
        .ACTIVE_SEL(active_sel),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle stamp: value k is visible from edge k until edge k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Increment pulses for a press first sampled at edge t0 and first sampled
    // released at edge er: first at t0+3, next HOLD later, then every REPEAT,
    // while the pulse edge is no later than er+2.
    task automatic push_inc_train(input int t0, input int er, input logic [2:0] v);
        int p;
        int n;
        p = t0 + 3;
        n = 0;
        while (p <= er + 2) begin
            exp_q.push_back('{t: p, clr: 3'b000, inc: v});
            p = p + ((n == 0) ? C_HOLD : C_REPEAT);
            n++;
        end
    endtask

    // Monitor: flag missed expectations, then match any presented pulse.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
            n_total++;
            $display("FAIL missed_pulse: expected at cyc %0d clr=%b inc=%b, no pulse presented",
                     exp_q[0].t, exp_q[0].clr, exp_q[0].inc);
            void'(exp_q.pop_front());
        end
        if (clr != '0 || inc != '0) begin
            if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_clr", 32'(clr), 32'(e.clr));
                check("pulse_inc", 32'(inc), 32'(e.inc));
            end else begin
                n_total++;
                $display("FAIL unexpected_pulse @cyc %0d: clr=%b inc=%b, expected none",
                         cyc, clr, inc);
            end
        end
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int t1;
        rst     = 1'b1;
        clr_btn = 1'b0;
        inc_btn = 1'b0;
        sel     = '0;

        // Reset state.
        wait_cyc(2);
        check("reset_clr",  32'(clr), 32'h0);
        check("reset_inc",  32'(inc), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_asel", 32'(active_sel), 32'h0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);

        // Single-cycle increment press on channel 2.
        t0 = cyc + 1;
        sel = 2'd2;
        inc_btn = 1'b1;
        push_inc_train(t0, t0 + 1, 3'b100);
        wait_cyc(t0);
        inc_btn = 1'b0;
        wait_cyc(t0 + 3);
        check("t2_busy_high", 32'(busy), 32'h1);
        check("t2_asel",      32'(active_sel), 32'h2);
        wait_cyc(t0 + 4);
        check("t2_busy_low",  32'(busy), 32'h0);
        wait_cyc(t0 + 10);

        // Increment held for 30 cycles on channel 1: hold then auto-repeat.
        t0 = cyc + 1;
        sel = 2'd1;
        inc_btn = 1'b1;
        push_inc_train(t0, t0 + 30, 3'b010);
        wait_cyc(t0 + 5);
        check("t3_asel", 32'(active_sel), 32'h1);
        wait_cyc(t0 + 29);
        inc_btn = 1'b0;
        wait_cyc(t0 + 40);
        check("t3_busy_low", 32'(busy), 32'h0);

        // Clear and increment rise together on channel 0: clear wins, lockout.
        t0 = cyc + 1;
        sel = 2'd0;
        inc_btn = 1'b1;
        clr_btn = 1'b1;
        exp_q.push_back('{t: t0 + 3, clr: 3'b001, inc: 3'b000});
        wait_cyc(t0 + 5);
        check("t4_busy_lockout", 32'(busy), 32'h1);
        wait_cyc(t0 + 9);
        inc_btn = 1'b0;
        clr_btn = 1'b0;
        wait_cyc(t0 + 12);
        check("t4_busy_until_release", 32'(busy), 32'h1);
        wait_cyc(t0 + 13);
        check("t4_busy_low", 32'(busy), 32'h0);
        wait_cyc(t0 + 18);

        // Select changes mid-hold are ignored.
        t0 = cyc + 1;
        sel = 2'd1;
        inc_btn = 1'b1;
        push_inc_train(t0, t0 + 20, 3'b010);
        wait_cyc(t0 + 6);
        sel = 2'd2;
        wait_cyc(t0 + 12);
        check("t5_asel_a", 32'(active_sel), 32'h1);
        wait_cyc(t0 + 18);
        check("t5_asel_b", 32'(active_sel), 32'h1);
        wait_cyc(t0 + 19);
        inc_btn = 1'b0;
        wait_cyc(t0 + 26);

        // Out-of-range select with a clear press: no pulses, still busy.
        t0 = cyc + 1;
        sel = 2'd3;
        clr_btn = 1'b1;
        wait_cyc(t0 + 3);
        check("t6_busy_high", 32'(busy), 32'h1);
        check("t6_asel",      32'(active_sel), 32'h3);
        wait_cyc(t0 + 4);
        clr_btn = 1'b0;
        wait_cyc(t0 + 7);
        check("t6_busy_until_release", 32'(busy), 32'h1);
        wait_cyc(t0 + 8);
        check("t6_busy_low",  32'(busy), 32'h0);
        check("t6_asel_hold", 32'(active_sel), 32'h3);
        wait_cyc(t0 + 12);

        // Reset in the middle of auto-repeat with the button still held.
        t0 = cyc + 1;
        sel = 2'd0;
        inc_btn = 1'b1;
        exp_q.push_back('{t: t0 + 3,  clr: 3'b000, inc: 3'b001});
        exp_q.push_back('{t: t0 + 11, clr: 3'b000, inc: 3'b001});
        exp_q.push_back('{t: t0 + 14, clr: 3'b000, inc: 3'b001});
        wait_cyc(t0 + 15);
        rst = 1'b1;
        wait_cyc(t0 + 16);
        check("t1_clr_zero",  32'(clr), 32'h0);
        check("t1_inc_zero",  32'(inc), 32'h0);
        check("t1_busy_zero", 32'(busy), 32'h0);
        check("t1_asel_zero", 32'(active_sel), 32'h0);
        rst = 1'b0;
        wait_cyc(t0 + 35);
        check("t1_idle_while_held", 32'(busy), 32'h0);
        inc_btn = 1'b0;
        wait_cyc(t0 + 40);
        t1 = cyc + 1;
        inc_btn = 1'b1;
        push_inc_train(t1, t1 + 1, 3'b001);
        wait_cyc(t1);
        inc_btn = 1'b0;
        wait_cyc(t1 + 3);
        check("t1_repress_busy", 32'(busy), 32'h1);
        wait_cyc(t1 + 12);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
